// File: rtl/core_alu_serial.sv
// core_alu_serial: byte-serial W-bit ALU (W = 8*BYTES) with optional BCD add/subtract,
// valid/ready/done handshake and abort. One 8-bit slice is reused for every byte;
// ops 0-6 walk LSB-first, lsr/ror walks MSB-first. Results and flags only change at
// completion, so an aborted job leaves the previous outputs intact.
module core_alu_serial #(
    parameter int BYTES      = 2,
    parameter int DECIMAL_EN = 1
) (
    input  logic                 I_clock,
    input  logic                 I_reset_n,
    input  logic                 I_valid,
    output logic                 O_ready,
    input  logic                 I_abort,
    input  logic [2:0]           I_op,
    input  logic                 I_invert_rhs,
    input  logic                 I_clear_carry,
    input  logic                 I_decimal,
    input  logic                 I_bit,
    input  logic                 I_mask_p,
    input  logic [8*BYTES-1:0]   I_lhs,
    input  logic [8*BYTES-1:0]   I_rhs,
    input  logic                 I_carry,
    input  logic                 I_overflow,
    input  logic                 I_sign,
    input  logic                 I_zero,
    output logic [8*BYTES-1:0]   O_result,
    output logic                 O_carry,
    output logic                 O_overflow,
    output logic                 O_sign,
    output logic                 O_zero,
    output logic                 O_done
);

    localparam int W  = 8 * BYTES;
    localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [KW-1:0] LAST = KW'(BYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_LHS = 3'd0,
        OP_RHS = 3'd1,
        OP_ADC = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_ASL = 3'd6,
        OP_LSR = 3'd7
    } op_t;

    // control / sequencing state
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            c_q, c_d;          // inter-byte carry / shift bit
    logic [W-1:0]    acc_q, acc_d;      // partial result, published only at completion
    logic [W-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;  // {C, V, N, Z}
    logic            done_q, done_d;

    // job captured at the accept edge
    op_t             op_q;
    logic            inv_q, dec_q, bit_q, mask_q;
    logic [W-1:0]    lhs_q, rhs_q;
    logic            cf_q, vf_q, nf_q, zf_q;

    // byte-slice datapath
    logic            accept;
    logic [W-1:0]    rhs_eff;
    logic [KW-1:0]   idx;
    logic [7:0]      lhs_b, rhs_b, res_b;
    logic [8:0]      bin9;
    logic [4:0]      lo5, hi5;
    logic            lo_dc, hi_dc;
    logic [3:0]      lo_nib, hi_nib;
    logic            v_b, cout;
    logic [W-1:0]    acc_nx;
    logic [3:0]      fin_flags;

    assign accept     = (state_q == S_IDLE) && I_valid;
    assign O_ready    = (state_q == S_IDLE);
    assign O_result   = result_q;
    assign O_carry    = flags_q[3];
    assign O_overflow = flags_q[2];
    assign O_sign     = flags_q[1];
    assign O_zero     = flags_q[0];
    assign O_done     = done_q;

    // Capture the whole request on accept so inputs are free to change afterwards.
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            op_q   <= OP_LHS;
            inv_q  <= 1'b0;
            dec_q  <= 1'b0;
            bit_q  <= 1'b0;
            mask_q <= 1'b0;
            lhs_q  <= '0;
            rhs_q  <= '0;
            cf_q   <= 1'b0;
            vf_q   <= 1'b0;
            nf_q   <= 1'b0;
            zf_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= op_t'(I_op);
            inv_q  <= I_invert_rhs;
            dec_q  <= I_decimal && (DECIMAL_EN != 0);
            bit_q  <= I_bit;
            mask_q <= I_mask_p;
            lhs_q  <= I_lhs;
            rhs_q  <= I_rhs;
            cf_q   <= I_carry;
            vf_q   <= I_overflow;
            nf_q   <= I_sign;
            zf_q   <= I_zero;
        end
    end

    // FSM state, byte counter, carry chain, accumulator and output registers.
    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            c_q      <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    // One byte of the selected operation plus the flags that completion would publish.
    always_comb begin
        rhs_eff = inv_q ? ~rhs_q : rhs_q;
        idx     = (op_q == OP_LSR) ? (LAST - k_q) : k_q;

        lhs_b = '0;
        rhs_b = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (idx == KW'(i)) begin
                lhs_b = lhs_q[i*8 +: 8];
                rhs_b = rhs_eff[i*8 +: 8];
            end
        end

        bin9 = {1'b0, lhs_b} + {1'b0, rhs_b} + {8'd0, c_q};

        // BCD: addition corrects nibbles that exceed 9; subtraction (rhs already
        // complemented) corrects nibbles that produced no carry, i.e. borrowed.
        lo5 = {1'b0, lhs_b[3:0]} + {1'b0, rhs_b[3:0]} + {4'd0, c_q};
        if (!inv_q) begin
            lo_dc  = (lo5 > 5'd9);
            lo_nib = lo_dc ? (lo5[3:0] + 4'd6) : lo5[3:0];
        end else begin
            lo_dc  = lo5[4];
            lo_nib = lo_dc ? lo5[3:0] : (lo5[3:0] - 4'd6);
        end
        hi5 = {1'b0, lhs_b[7:4]} + {1'b0, rhs_b[7:4]} + {4'd0, lo_dc};
        if (!inv_q) begin
            hi_dc  = (hi5 > 5'd9);
            hi_nib = hi_dc ? (hi5[3:0] + 4'd6) : hi5[3:0];
        end else begin
            hi_dc  = hi5[4];
            hi_nib = hi_dc ? hi5[3:0] : (hi5[3:0] - 4'd6);
        end

        // binary overflow of this byte, taken before any decimal correction
        v_b = (lhs_b[7] == rhs_b[7]) && (bin9[7] != lhs_b[7]);

        res_b = lhs_b;
        cout  = c_q;
        unique case (op_q)
            OP_LHS: res_b = lhs_b;
            OP_RHS: res_b = rhs_b;
            OP_ADC: begin
                if (dec_q) begin
                    res_b = {hi_nib, lo_nib};
                    cout  = hi_dc;
                end else begin
                    res_b = bin9[7:0];
                    cout  = bin9[8];
                end
            end
            OP_AND: res_b = lhs_b & rhs_b;
            OP_OR:  res_b = lhs_b | rhs_b;
            OP_XOR: res_b = lhs_b ^ rhs_b;
            OP_ASL: begin
                res_b = {lhs_b[6:0], c_q};
                cout  = lhs_b[7];
            end
            OP_LSR: begin
                res_b = {c_q, lhs_b[7:1]};
                cout  = lhs_b[0];
            end
            default: res_b = lhs_b;
        endcase

        acc_nx = acc_q;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (idx == KW'(i)) begin
                acc_nx[i*8 +: 8] = res_b;
            end
        end

        // On the final byte acc_nx is the full result and, for adc, the current
        // byte is the top byte, so v_b is the top-byte overflow.
        if (mask_q) begin
            fin_flags[3] = (op_q == OP_ADC || op_q == OP_ASL || op_q == OP_LSR) ? cout : cf_q;
            fin_flags[2] = bit_q ? rhs_q[W-2] : ((op_q == OP_ADC) ? v_b : vf_q);
            fin_flags[1] = bit_q ? rhs_q[W-1] : acc_nx[W-1];
            fin_flags[0] = (acc_nx == '0);
        end else begin
            fin_flags = {cf_q, vf_q, nf_q, zf_q};
        end
    end

    // Next-state logic: accept, per-byte stepping, abort and completion.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        c_d      = c_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (I_valid) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    c_d     = I_carry & ~I_clear_carry;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (I_abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_nx;
                    c_d   = cout;
                    if (k_q == LAST) begin
                        state_d  = S_IDLE;
                        result_d = acc_nx;
                        flags_d  = fin_flags;
                        done_d   = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/core_alu_serial.md
Name: core_alu_serial

Overview:
- Parametrised successor to the core 8-bit ALU.
- Operands are 8*BYTES wide and processed byte-serially, one byte per clock, through a single 8-bit datapath slice.
- Adds an optional BCD (decimal) add/subtract mode and a valid/ready/done handshake with abort.
- Sits beside the core ALU for multi-byte address/pointer arithmetic and decimal-capable instruction variants.

Parameters:
- BYTES, 2: operand width in bytes, minimum 1; W = 8*BYTES.
- DECIMAL_EN, 1: 1 enables BCD correction; 0 makes I_decimal ignored.

Ports:
- I_clock  in  1  clock, rising-edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_valid  in  1  request; accepted when I_valid && O_ready at a rising edge.
- O_ready  out  1  high when idle (combinational from state).
- I_abort  in  1  cancels an operation in progress.
- I_op  in  3  0 =lhs, 1 =rhs, 2 adc, 3 and, 4 or, 5 xor, 6 asl/rol, 7 lsr/ror.
- I_invert_rhs  in  1  rhs is one's-complemented before the op (subtract with adc).
- I_clear_carry  in  1  forces carry-in to 0.
- I_decimal  in  1  BCD mode for op 2.
- I_bit  in  1  BIT-style flags: N and V taken from rhs.
- I_mask_p  in  1  1 = update flags, 0 = pass input flags through.
- I_lhs  in  W  left operand.
- I_rhs  in  W  right operand.
- I_carry, I_overflow, I_sign, I_zero  in  1 each  incoming flags.
- O_result  out  W  result.
- O_carry, O_overflow, O_sign, O_zero  out  1 each  flags.
- O_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, I_reset_n low): state IDLE; O_result = 0; all flags 0; O_done = 0; O_ready = 1. Reset mid-operation discards the job.
- Accept: all inputs are captured into internal registers at the accept edge; inputs may change afterwards. Carry-in is I_carry, or 0 if I_clear_carry. rhs' is ~I_rhs if I_invert_rhs, else I_rhs.
- States:
  - IDLE -> RUN on accept; byte counter k = 0.
  - RUN processes one byte per cycle.
  - Ops 0-6 go LSB-first, k = 0..BYTES-1.
  - Op 7 goes MSB-first.
  - The inter-byte carry/shift bit is held in a register.
  - RUN -> IDLE after byte BYTES-1.
- Completion: at the final RUN edge, O_result and flags are updated and O_done is registered high for exactly 1 cycle.
- Latency: O_done is high in the cycle starting BYTES edges after the accept edge. O_ready is high in the O_done cycle, so back-to-back accepts are allowed.
- Hold: O_result and flags hold between completions; partial bytes are written to O_result only at completion.
- Abort: I_abort in RUN -> IDLE at the next edge. No O_done, outputs unchanged. Abort wins over completion in the same cycle. I_abort is ignored in IDLE.
- Arithmetic per op:
  - adc: {c, byte} = lhs_k + rhs'_k + c.
  - Decimal (I_decimal && DECIMAL_EN, op 2):
    - Add (invert 0): per nibble, if the binary nibble sum > 9 or the nibble carries, add 6 and propagate a nibble carry.
    - Subtract (invert 1): per nibble, if there is no nibble carry-out, subtract 6 from that nibble.
    - Decimal results are defined only for valid BCD inputs.
  - and/or/xor/=lhs/=rhs: bytewise; carry passes through unchanged.
  - asl: shift-in = carry-in, carry out = lhs[W-1].
  - lsr: shift-in = carry-in at bit W-1, carry out = lhs[0].
- Flags when I_mask_p = 1:
  - C: adc/asl/lsr carry out; otherwise I_carry.
  - V: if I_bit, rhs[W-2]; else for adc, binary overflow of the top byte (lhs[W-1] == rhs'[W-1] && result MSB differs, pre-decimal-correction); else I_overflow.
  - N: I_bit ? I_rhs[W-1] : result[W-1].
  - Z: 1 iff the entire W-bit final result is 0, accumulated across bytes.
- Flags when I_mask_p = 0: all flags equal the captured input flags; O_result is still updated.
- BYTES = 1: latency 1. Semantics match the 8-bit core ALU, except that binary adc carry-out and N/Z/V update when I_mask_p = 1.

Test Plan:
- BYTES = 2, adc, lhs 0x12FF, rhs 0x0001, carry 0 -> result 0x1300, C0 V0 N0 Z0; O_done exactly 2 cycles after accept, 1 cycle wide.
- adc with invert_rhs = 1, carry 1, lhs 0x8000, rhs 0x0001 -> 0x7FFF, C1 V1 N0 Z0.
- Decimal adc, carry 0: 0x0999 + 0x0001 -> 0x1000 C0; 0x9999 + 0x0001 -> 0x0000 C1 Z1. Decimal sub: 0x1000 - 0x0001 (invert, carry 1) -> 0x0999 C1.
- lsr, lhs 0x0001, carry 1 -> 0x8000 C1 N1 Z0. asl, lhs 0x8000, carry 0 -> 0x0000 C1 Z1.
- Abort and back-to-back:
  - Abort 1 cycle after accept -> no O_done, outputs keep the prior values, O_ready high the next cycle.
  - Second accept in the O_done cycle completes 2 cycles later.
  - I_reset_n low mid-RUN -> all outputs 0 immediately.
- mask_p = 0, and, lhs 0xF0F0, rhs 0x0F0F, input flags C1 V1 N0 Z0 -> result 0x0000, flags C1 V1 N0 Z0. I_bit with rhs 0xC000 -> N1 V1, Z1 from lhs & rhs = 0.
